// File: rtl/rpi_frame_rx.sv
// Receive stage from the Pi GPIO bus: synchronises strobe/frame, runs the four-phase byte
// handshake, parses the header/key/plaintext frame and feeds the core's byte-load interface.
// Optional inter-byte timeout when RX_TIMEOUT_EN is defined.
module rpi_frame_rx #(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [6:0] HDR_TAG        = 7'b1010010,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rpi_data,
  input  logic       rpi_strobe,
  input  logic       rpi_frame,
  output logic       rpi_ack,
  input  logic       seed_done,
  output logic [7:0] part_msg,
  output logic       in_en,
  output logic       load,
  output logic       start,
  output logic       Enc_Dec,
  output logic       busy,
  output logic       frame_err
);

  // state  | meaning
  // S_IDLE | waiting for a header byte inside a frame
  // S_KEY  | forwarding 16 key bytes with load high
  // S_TXT  | forwarding 16 plaintext bytes
  // S_FIRE | issuing the one-cycle start pulse
  // S_WAIT | core busy; strobes are acked but flagged as overrun
  typedef enum logic [2:0] {S_IDLE, S_KEY, S_TXT, S_FIRE, S_WAIT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [SYNC_STAGES-1:0] frame_sync;
  logic                   strobe_prev;
  logic                   frame_prev;
  logic                   strobe_s;
  logic                   frame_s;
  logic                   str_rise;
  logic                   frame_fall;
  logic                   rx_vld;
  logic                   rx_frame;
  logic                   rx_fall;
  logic [7:0]             rx_byte;
  logic [3:0]             cnt;
`ifdef RX_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0]            tmo_cnt;
`endif

  assign strobe_s   = strobe_sync[SYNC_STAGES-1];
  assign frame_s    = frame_sync[SYNC_STAGES-1];
  assign str_rise   = strobe_s & ~strobe_prev;
  assign frame_fall = frame_prev & ~frame_s;

  // Capture stage: data is sampled on str_rise and the frame fall is aligned with it, so the
  // FSM sees a coincident byte and abort in the same cycle and can let the abort win.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_sync <= '0;
      frame_sync  <= '0;
      strobe_prev <= 1'b0;
      frame_prev  <= 1'b0;
      rx_vld      <= 1'b0;
      rx_frame    <= 1'b0;
      rx_fall     <= 1'b0;
      rx_byte     <= 8'h00;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], rpi_strobe};
      frame_sync  <= {frame_sync[SYNC_STAGES-2:0], rpi_frame};
      strobe_prev <= strobe_s;
      frame_prev  <= frame_s;
      rx_vld      <= str_rise & ~rpi_ack;
      rx_frame    <= frame_s;
      rx_fall     <= frame_fall;
      if (str_rise)
        rx_byte <= rpi_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rpi_ack   <= 1'b0;
      part_msg  <= 8'h00;
      in_en     <= 1'b0;
      load      <= 1'b0;
      start     <= 1'b0;
      Enc_Dec   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_cnt   <= 16'd0;
`endif
    end else begin
      in_en <= 1'b0;
      load  <= 1'b0;
      start <= 1'b0;
      if (rx_vld)
        rpi_ack <= 1'b1;
      else if (rpi_ack && !strobe_s)
        rpi_ack <= 1'b0;
`ifdef RX_TIMEOUT_EN
      if (rx_vld)
        tmo_cnt <= 16'd0;
      else if (state == S_KEY || state == S_TXT)
        tmo_cnt <= tmo_cnt + 16'd1;
`endif
      case (state)
        S_IDLE: begin
          if (rx_vld && rx_frame) begin
            if (rx_byte[7:1] == HDR_TAG) begin
              Enc_Dec   <= rx_byte[0];
              frame_err <= 1'b0;
              busy      <= 1'b1;
              cnt       <= 4'd0;
              state     <= S_KEY;
`ifdef RX_TIMEOUT_EN
              tmo_cnt   <= 16'd0;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        S_KEY, S_TXT: begin
          if (rx_fall) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            cnt       <= 4'd0;
            state     <= S_IDLE;
          end else if (rx_vld) begin
            part_msg <= rx_byte;
            in_en    <= 1'b1;
            load     <= (state == S_KEY);
            cnt      <= cnt + 4'd1;
            if (cnt == 4'd15)
              state <= (state == S_KEY) ? S_TXT : S_FIRE;
          end
`ifdef RX_TIMEOUT_EN
          else if (tmo_cnt == TMO_LIMIT) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            cnt       <= 4'd0;
            rpi_ack   <= 1'b0;
            state     <= S_IDLE;
          end
`endif
        end
        S_FIRE: begin
          start <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (rx_vld)
            frame_err <= 1'b1;
          if (seed_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
